m2vside2: RTL and testbench
===========================

Name: m2vside2

Overview:
- Stage-2 side-information buffer, directly downstream of the stage-1 side-info container.
- Captures the stage-1 block descriptor (motion vector, macroblock position, intra flag, block index, coded flag) each time dequant finishes a block, and queues it in a small FIFO.
- Presents the descriptors in order to the IDCT/motion-compensation stage, adding derived pixel coordinates and plane flags.
- Decouples the VLD/dequant block rate from the IDCT/MC consumption rate.

Parameters:
- MVH_WIDTH, 16, horizontal motion vector width
- MVV_WIDTH, 15, vertical motion vector width
- MBX_WIDTH, 6, macroblock column width
- MBY_WIDTH, 5, macroblock row width
- DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 entries (allowed range 1..4)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous active-high reset
- s1_push  in  1  pulse: stage-1 block finished; capture s1_* this cycle
- s1_mv_h  in  MVH_WIDTH  motion vector horizontal
- s1_mv_v  in  MVV_WIDTH  motion vector vertical
- s1_mb_x  in  MBX_WIDTH  macroblock column
- s1_mb_y  in  MBY_WIDTH  macroblock row
- s1_mb_intra  in  1  intra macroblock
- s1_block  in  3  block index 0..5
- s1_coded  in  1  block has coefficients
- s1_enable  in  1  descriptor valid; push ignored when 0
- s1_full  out  1  FIFO full; upstream must not push
- s2_pop  in  1  consumer takes current head
- s2_valid  out  1  s2_* outputs hold a valid descriptor
- s2_mv_h, s2_mv_v, s2_mb_x, s2_mb_y, s2_mb_intra, s2_block, s2_coded  out  same widths  head descriptor
- s2_luma  out  1  block index < 4
- s2_cbcr  out  1  chroma plane select: 0 = Cb (block 4), 1 = Cr (block 5); 0 for luma
- s2_pix_x  out  MBX_WIDTH+4  top-left pixel column within the block's plane
- s2_pix_y  out  MBY_WIDTH+4  top-left pixel row within the block's plane
- s2_err  out  2  sticky: [0] overflow (push while full, no pop), [1] illegal block index (6/7)

Behaviour:
- Reset: all outputs 0, FIFO empty, s1_full=0, s2_valid=0, s2_err=0. Reset mid-operation discards all queued entries immediately (asynchronous).
- Push qualifier: s1_push & s1_enable. s1_push with s1_enable=0 has no effect.
- Push while full with no pop in the same cycle: descriptor dropped, s2_err[0] set, FIFO state unchanged.
- Push with s1_block>5: dropped, s2_err[1] set. s2_err bits clear only on reset.
- Output register is show-ahead and counts as one FIFO slot. Total capacity is 2**DEPTH_LOG2 entries including the output register.
- Latency: a push into an empty FIFO gives s2_valid=1 with that descriptor on the next cycle.
- s2_pop when s2_valid=1: the next entry (if any) loads the output registers on the following edge, otherwise s2_valid drops to 0. s2_pop when s2_valid=0 is ignored.
- Simultaneous push and pop:
  - Always accepted, including when full; occupancy unchanged.
  - When exactly one entry is held, the pushed entry becomes the head next cycle.
- s1_full is registered and equals (occupancy == depth). It deasserts the cycle after a pop from full.
- Pointers wrap modulo depth; occupancy counter is DEPTH_LOG2+1 bits.
- Derived fields are computed at head load time and registered; they are stable while s2_valid=1 and no pop occurs.
  - Luma (blocks 0..3):
    - s2_pix_x = mb_x*16 + block[0]*8
    - s2_pix_y = mb_y*16 + block[1]*8
    - s2_luma = 1
  - Chroma 4:2:0 (blocks 4,5):
    - s2_pix_x = mb_x*8
    - s2_pix_y = mb_y*8
    - s2_luma = 0
    - s2_cbcr = block[0]
  - Zero-extended unsigned arithmetic, no overflow possible at the given widths.
- Motion vectors pass through unmodified (two's complement, widths preserved).

Optional Feature:
- Macro M2VSIDE2_LEVEL_EN.
- When defined: adds output s2_level (DEPTH_LOG2+1 bits) = current occupancy, registered, reset 0; updates in the same cycle as s1_full.
- When undefined: port absent, no extra logic.

Decomposition:
- Shared include m2vdefs.vh holds:
  - block index constants (BLK_Y0..BLK_Y3=0..3, BLK_CB=4, BLK_CR=5)
  - s2_err bit positions
  - descriptor field width localparams, also used by the stage-1 container
- One sub-module m2vside2_fifo: generic register-array FIFO with a show-ahead output register, parameterized data width and DEPTH_LOG2. The top level handles packing, the push qualifier, error flags and derived coordinates.

Test Plan:
- Push block 3, mb_x=5, mb_y=2, into empty FIFO -> next cycle s2_valid=1, s2_pix_x=88, s2_pix_y=40, s2_luma=1.
- Push block 5, mb_x=10, mb_y=3 -> s2_pix_x=80, s2_pix_y=24, s2_luma=0, s2_cbcr=1.
- DEPTH_LOG2=2, four pushes without pop -> s1_full=1. Fifth push -> dropped, s2_err=2'b01. Four pops then return the four entries in order.
- Full FIFO with push and pop in the same cycle -> new entry accepted, no error, occupancy stays 4, ordering preserved.
- Push with s1_block=6 -> not queued, s2_err[1]=1. Push with s1_enable=0 -> no effect. Pop while empty -> no effect.
- Assert reset with 3 entries queued -> s2_valid, s1_full and s2_err all 0 immediately. The first push after reset appears 1 cycle later.

Source files
------------

// File: rtl/m2vside2_pkg.sv
// m2vside2_pkg: definitions shared by the stage-1 container and the stage-2
// side-info buffer. It holds the block index constants, the s2_err bit
// positions and the default descriptor field widths.
package m2vside2_pkg;

  // Default descriptor field widths, shared with the stage-1 container
  localparam int MVH_WIDTH_DEF  = 16;
  localparam int MVV_WIDTH_DEF  = 15;
  localparam int MBX_WIDTH_DEF  = 6;
  localparam int MBY_WIDTH_DEF  = 5;
  localparam int BLK_WIDTH      = 3;
  localparam int DEPTH_LOG2_DEF = 2;

  // Block indices within a 4:2:0 macroblock
  localparam logic [BLK_WIDTH-1:0] BLK_Y0 = 3'd0;
  localparam logic [BLK_WIDTH-1:0] BLK_Y1 = 3'd1;
  localparam logic [BLK_WIDTH-1:0] BLK_Y2 = 3'd2;
  localparam logic [BLK_WIDTH-1:0] BLK_Y3 = 3'd3;
  localparam logic [BLK_WIDTH-1:0] BLK_CB = 3'd4;
  localparam logic [BLK_WIDTH-1:0] BLK_CR = 3'd5;

  // s2_err bit positions
  localparam int ERR_OVF = 0;
  localparam int ERR_BLK = 1;

endpackage

// File: rtl/m2vside2_fifo.sv
// m2vside2_fifo: register-array FIFO with a show-ahead output register.
// The output register counts as one slot, so the array never holds more
// than DEPTH-1 entries. Equal pointers therefore always mean "array empty".
module m2vside2_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [WIDTH-1:0]      head_q, head_d;
  logic                  valid_q, valid_d;
  logic                  full_q, full_d;

  logic pop_eff, push_acc, need_head, mem_empty, load_mem, bypass, mem_we;

  // Next-state: head refill from the array, or bypass straight from din
  always_comb begin
    pop_eff   = pop & valid_q;
    push_acc  = push & (~full_q | pop_eff);
    need_head = ~valid_q | pop_eff;
    mem_empty = (wr_ptr_q == rd_ptr_q);
    load_mem  = need_head & ~mem_empty;
    bypass    = need_head & mem_empty & push_acc;
    mem_we    = push_acc & ~bypass;

    head_d  = head_q;
    valid_d = valid_q;
    if (need_head) begin
      valid_d = load_mem | bypass;
      if (load_mem) begin
        head_d = mem_q[rd_ptr_q];
      end else if (bypass) begin
        head_d = din;
      end
    end

    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(load_mem);
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(mem_we);
    count_d  = count_q + CNT_W'(push_acc) - CNT_W'(pop_eff);
    full_d   = (count_d == DEPTH_CNT);
  end

  // Control and head registers; reset empties the FIFO immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = head_q;
  assign valid = valid_q;
  assign full  = full_q;
  assign level = count_q;

endmodule

// File: rtl/m2vside2.sv
// m2vside2: stage-2 side-information buffer. Queues stage-1 block
// descriptors and presents them to IDCT/MC with pixel coordinates and plane
// flags. Optional build macro M2VSIDE2_LEVEL_EN adds the s2_level output
// (registered FIFO occupancy).
module m2vside2
  import m2vside2_pkg::*;
#(
  parameter int MVH_WIDTH  = MVH_WIDTH_DEF,
  parameter int MVV_WIDTH  = MVV_WIDTH_DEF,
  parameter int MBX_WIDTH  = MBX_WIDTH_DEF,
  parameter int MBY_WIDTH  = MBY_WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s1_push,
  input  logic [MVH_WIDTH-1:0]  s1_mv_h,
  input  logic [MVV_WIDTH-1:0]  s1_mv_v,
  input  logic [MBX_WIDTH-1:0]  s1_mb_x,
  input  logic [MBY_WIDTH-1:0]  s1_mb_y,
  input  logic                  s1_mb_intra,
  input  logic [2:0]            s1_block,
  input  logic                  s1_coded,
  input  logic                  s1_enable,
  output logic                  s1_full,
  input  logic                  s2_pop,
  output logic                  s2_valid,
  output logic [MVH_WIDTH-1:0]  s2_mv_h,
  output logic [MVV_WIDTH-1:0]  s2_mv_v,
  output logic [MBX_WIDTH-1:0]  s2_mb_x,
  output logic [MBY_WIDTH-1:0]  s2_mb_y,
  output logic                  s2_mb_intra,
  output logic [2:0]            s2_block,
  output logic                  s2_coded,
  output logic                  s2_luma,
  output logic                  s2_cbcr,
  output logic [MBX_WIDTH+3:0]  s2_pix_x,
  output logic [MBY_WIDTH+3:0]  s2_pix_y,
  output logic [1:0]            s2_err
`ifdef M2VSIDE2_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   s2_level
`endif
);

  localparam int PX_W   = MBX_WIDTH + 4;
  localparam int PY_W   = MBY_WIDTH + 4;
  localparam int DESC_W = MVH_WIDTH + MVV_WIDTH + MBX_WIDTH + MBY_WIDTH + 5;
  localparam int WORD_W = DESC_W + 2 + PX_W + PY_W;

  logic              push_qual, blk_ok, fifo_push, fifo_full, fifo_valid, pop_eff;
  logic              luma_in, cbcr_in;
  logic [PX_W-1:0]   pix_x_in;
  logic [PY_W-1:0]   pix_y_in;
  logic [WORD_W-1:0] fifo_din, fifo_dout;
  logic [1:0]        err_q, err_d;

  // Push qualification and plane coordinates. The descriptor is immutable
  // once captured, so deriving here and carrying the result with it gives
  // the same registered head values as deriving when the head loads.
  always_comb begin
    push_qual = s1_push & s1_enable;
    blk_ok    = (s1_block <= BLK_CR);
    fifo_push = push_qual & blk_ok;
    luma_in   = (s1_block < BLK_CB);
    if (luma_in) begin
      cbcr_in  = 1'b0;
      pix_x_in = {s1_mb_x, 4'b0000} + PX_W'({s1_block[0], 3'b000});
      pix_y_in = {s1_mb_y, 4'b0000} + PY_W'({s1_block[1], 3'b000});
    end else begin
      cbcr_in  = s1_block[0];
      pix_x_in = PX_W'({s1_mb_x, 3'b000});
      pix_y_in = PY_W'({s1_mb_y, 3'b000});
    end
    fifo_din = {s1_mv_h, s1_mv_v, s1_mb_x, s1_mb_y, s1_mb_intra, s1_block,
                s1_coded, luma_in, cbcr_in, pix_x_in, pix_y_in};
  end

  // Sticky error flags: overflow only when no pop frees a slot this cycle
  always_comb begin
    pop_eff = s2_pop & fifo_valid;
    err_d   = err_q;
    if (push_qual & ~blk_ok) begin
      err_d[ERR_BLK] = 1'b1;
    end
    if (fifo_push & fifo_full & ~pop_eff) begin
      err_d[ERR_OVF] = 1'b1;
    end
  end

  // Error register, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

`ifndef M2VSIDE2_LEVEL_EN
  logic [DEPTH_LOG2:0] level_unused;
`endif

  m2vside2_fifo #(
    .WIDTH      (WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (s2_pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .full  (fifo_full),
`ifdef M2VSIDE2_LEVEL_EN
    .level (s2_level)
`else
    .level (level_unused)
`endif
  );

  assign {s2_mv_h, s2_mv_v, s2_mb_x, s2_mb_y, s2_mb_intra, s2_block,
          s2_coded, s2_luma, s2_cbcr, s2_pix_x, s2_pix_y} = fifo_dout;
  assign s2_valid = fifo_valid;
  assign s1_full  = fifo_full;
  assign s2_err   = err_q;

endmodule

// File: tb/tb_m2vside2.sv
module tb_m2vside2;

  logic        clk;
  logic        reset;
  logic        s1_push;
  logic [15:0] s1_mv_h;
  logic [14:0] s1_mv_v;
  logic [5:0]  s1_mb_x;
  logic [4:0]  s1_mb_y;
  logic        s1_mb_intra;
  logic [2:0]  s1_block;
  logic        s1_coded;
  logic        s1_enable;
  logic        s1_full;
  logic        s2_pop;
  logic        s2_valid;
  logic [15:0] s2_mv_h;
  logic [14:0] s2_mv_v;
  logic [5:0]  s2_mb_x;
  logic [4:0]  s2_mb_y;
  logic        s2_mb_intra;
  logic [2:0]  s2_block;
  logic        s2_coded;
  logic        s2_luma;
  logic        s2_cbcr;
  logic [9:0]  s2_pix_x;
  logic [8:0]  s2_pix_y;
  logic [1:0]  s2_err;

  int n_tests = 0;
  int n_fail  = 0;

  m2vside2 dut (
    .clk         (clk),
    .reset       (reset),
    .s1_push     (s1_push),
    .s1_mv_h     (s1_mv_h),
    .s1_mv_v     (s1_mv_v),
    .s1_mb_x     (s1_mb_x),
    .s1_mb_y     (s1_mb_y),
    .s1_mb_intra (s1_mb_intra),
    .s1_block    (s1_block),
    .s1_coded    (s1_coded),
    .s1_enable   (s1_enable),
    .s1_full     (s1_full),
    .s2_pop      (s2_pop),
    .s2_valid    (s2_valid),
    .s2_mv_h     (s2_mv_h),
    .s2_mv_v     (s2_mv_v),
    .s2_mb_x     (s2_mb_x),
    .s2_mb_y     (s2_mb_y),
    .s2_mb_intra (s2_mb_intra),
    .s2_block    (s2_block),
    .s2_coded    (s2_coded),
    .s2_luma     (s2_luma),
    .s2_cbcr     (s2_cbcr),
    .s2_pix_x    (s2_pix_x),
    .s2_pix_y    (s2_pix_y),
    .s2_err      (s2_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mv_v, intra and coded are derived from mv_h so each entry is identifiable
  task automatic drive(input logic p, input logic en, input logic [2:0] blk,
                       input logic [5:0] mbx, input logic [4:0] mby,
                       input logic [15:0] mvh, input logic pop);
    s1_push     = p;
    s1_enable   = en;
    s1_block    = blk;
    s1_mb_x     = mbx;
    s1_mb_y     = mby;
    s1_mv_h     = mvh;
    s1_mv_v     = ~mvh[14:0];
    s1_mb_intra = mvh[0];
    s1_coded    = mvh[1];
    s2_pop      = pop;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] mvh, input logic [2:0] blk,
                          input logic [5:0] mbx, input logic [4:0] mby,
                          input int px, input int py, input logic luma, input logic cbcr);
    logic [14:0] mvv;
    mvv = ~mvh[14:0];
    chk({tag, ".valid"}, 32'(s2_valid), 32'd1);
    chk({tag, ".mv_h"},  32'(s2_mv_h), 32'(mvh));
    chk({tag, ".mv_v"},  32'(s2_mv_v), 32'(mvv));
    chk({tag, ".mb_x"},  32'(s2_mb_x), 32'(mbx));
    chk({tag, ".mb_y"},  32'(s2_mb_y), 32'(mby));
    chk({tag, ".intra"}, 32'(s2_mb_intra), 32'(mvh[0]));
    chk({tag, ".coded"}, 32'(s2_coded), 32'(mvh[1]));
    chk({tag, ".block"}, 32'(s2_block), 32'(blk));
    chk({tag, ".pix_x"}, 32'(s2_pix_x), 32'(px));
    chk({tag, ".pix_y"}, 32'(s2_pix_y), 32'(py));
    chk({tag, ".luma"},  32'(s2_luma), 32'(luma));
    chk({tag, ".cbcr"},  32'(s2_cbcr), 32'(cbcr));
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 3'd0, 6'd0, 5'd0, 16'h0000, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 32'(s2_valid), 32'd0);
    chk("rst.full",  32'(s1_full), 32'd0);
    chk("rst.err",   32'(s2_err), 32'd0);
    chk("rst.pix_x", 32'(s2_pix_x), 32'd0);
    reset = 1'b0;
    tick();

    // Luma block 3 of MB (5,2): 5*16+8, 2*16+8
    drive(1, 1, 3'd3, 6'd5, 5'd2, 16'h1113, 0);
    tick();
    drive(0, 1, 3'd0, 6'd0, 5'd0, 16'h0000, 0);
    chk_head("luma3", 16'h1113, 3'd3, 6'd5, 5'd2, 88, 40, 1'b1, 1'b0);
    tick();
    chk_head("luma3.hold", 16'h1113, 3'd3, 6'd5, 5'd2, 88, 40, 1'b1, 1'b0);
    drive(0, 1, 3'd0, 6'd0, 5'd0, 16'h0000, 1);
    tick();
    chk("luma3.popped", 32'(s2_valid), 32'd0);

    // Cr block of MB (10,3): 10*8, 3*8; negative motion vector
    drive(1, 1, 3'd5, 6'd10, 5'd3, 16'h8002, 0);
    tick();
    drive(0, 1, 3'd0, 6'd0, 5'd0, 16'h0000, 1);
    chk_head("cr", 16'h8002, 3'd5, 6'd10, 5'd3, 80, 24, 1'b0, 1'b1);
    tick();
    chk("cr.popped", 32'(s2_valid), 32'd0);

    // Fill to capacity: A1..A4
    drive(1, 1, 3'd0, 6'd1, 5'd1, 16'hA001, 0); tick();
    drive(1, 1, 3'd1, 6'd1, 5'd1, 16'hA002, 0); tick();
    drive(1, 1, 3'd2, 6'd1, 5'd1, 16'hA003, 0); tick();
    chk("fill3.full", 32'(s1_full), 32'd0);
    drive(1, 1, 3'd4, 6'd1, 5'd1, 16'hA004, 0); tick();
    chk("fill4.full", 32'(s1_full), 32'd1);
    chk("fill4.err",  32'(s2_err), 32'd0);
    // Overflow: A5 dropped
    drive(1, 1, 3'd3, 6'd7, 5'd7, 16'hA005, 0); tick();
    chk("ovf.err",  32'(s2_err), 32'b01);
    chk("ovf.full", 32'(s1_full), 32'd1);
    chk_head("ovf.head", 16'hA001, 3'd0, 6'd1, 5'd1, 16, 16, 1'b1, 1'b0);
    // Push and pop together while full: A6 accepted, A1 leaves
    drive(1, 1, 3'd3, 6'd2, 5'd0, 16'hA006, 1); tick();
    drive(0, 1, 3'd0, 6'd0, 5'd0, 16'h0000, 0);
    chk("pp.err",  32'(s2_err), 32'b01);
    chk("pp.full", 32'(s1_full), 32'd1);
    chk_head("pp.A2", 16'hA002, 3'd1, 6'd1, 5'd1, 24, 16, 1'b1, 1'b0);
    drive(0, 1, 3'd0, 6'd0, 5'd0, 16'h0000, 1); tick();
    chk("pop1.full", 32'(s1_full), 32'd0);
    chk_head("pop1.A3", 16'hA003, 3'd2, 6'd1, 5'd1, 16, 24, 1'b1, 1'b0);
    tick();
    chk_head("pop2.A4", 16'hA004, 3'd4, 6'd1, 5'd1, 8, 8, 1'b0, 1'b0);
    tick();
    chk_head("pop3.A6", 16'hA006, 3'd3, 6'd2, 5'd0, 40, 8, 1'b1, 1'b0);
    tick();
    chk("pop4.valid", 32'(s2_valid), 32'd0);
    chk("pop4.full",  32'(s1_full), 32'd0);

    // Illegal block index
    drive(1, 1, 3'd6, 6'd3, 5'd3, 16'hB006, 0); tick();
    chk("blk6.valid", 32'(s2_valid), 32'd0);
    chk("blk6.err",   32'(s2_err), 32'b11);
    // Push with enable low
    drive(1, 0, 3'd1, 6'd3, 5'd3, 16'hB001, 0); tick();
    chk("noen.valid", 32'(s2_valid), 32'd0);
    // Pop while empty
    drive(0, 1, 3'd0, 6'd0, 5'd0, 16'h0000, 1); tick();
    chk("popempty.valid", 32'(s2_valid), 32'd0);
    chk("popempty.full",  32'(s1_full), 32'd0);

    // One entry held, push and pop together: new entry becomes head
    drive(1, 1, 3'd0, 6'd0, 5'd0, 16'hC001, 0); tick();
    chk_head("one.C1", 16'hC001, 3'd0, 6'd0, 5'd0, 0, 0, 1'b1, 1'b0);
    drive(1, 1, 3'd5, 6'd63, 5'd31, 16'hC002, 1); tick();
    drive(0, 1, 3'd0, 6'd0, 5'd0, 16'h0000, 0);
    chk_head("one.C2", 16'hC002, 3'd5, 6'd63, 5'd31, 504, 248, 1'b0, 1'b1);
    // Two more behind C2, then asynchronous reset with 3 queued
    drive(1, 1, 3'd1, 6'd4, 5'd4, 16'hC003, 0); tick();
    drive(1, 1, 3'd2, 6'd4, 5'd4, 16'hC004, 0); tick();
    drive(0, 1, 3'd0, 6'd0, 5'd0, 16'h0000, 0);
    chk("pre_rst.valid", 32'(s2_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.valid", 32'(s2_valid), 32'd0);
    chk("arst.full",  32'(s1_full), 32'd0);
    chk("arst.err",   32'(s2_err), 32'd0);
    #1;
    reset = 1'b0;
    // Max coordinates after reset: luma block 3 of MB (63,31)
    drive(1, 1, 3'd3, 6'd63, 5'd31, 16'hD003, 0);
    tick();
    drive(0, 1, 3'd0, 6'd0, 5'd0, 16'h0000, 0);
    chk_head("post_rst.D1", 16'hD003, 3'd3, 6'd63, 5'd31, 1016, 504, 1'b1, 1'b0);
    drive(0, 1, 3'd0, 6'd0, 5'd0, 16'h0000, 1); tick();
    chk("post_rst.popped", 32'(s2_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
